// File: rtl/div8s_pkg.sv
// Shared definitions for the sequential sign-magnitude divider: FSM encoding
// and the iteration-counter width helper.
package div8s_pkg;

    localparam int DIV_N = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Wide enough to count 0..2N inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(2 * n + 1);
    endfunction

    localparam int CNT_W = cnt_width(DIV_N);

endpackage

// File: rtl/div8s_seq_if.sv
// Start/busy/done handshake plus sign-magnitude operand and result buses
// of the sequential divider.
interface div8s_seq_if #(
    parameter int N = 4
);
    logic           start;
    logic [2*N-1:0] a_mag;
    logic           a_sign;
    logic [N-1:0]   b_mag;
    logic           b_sign;
    logic           busy;
    logic           done;
    logic [2*N-1:0] q_mag;
    logic           q_sign;
    logic [N-1:0]   r_mag;
    logic           r_sign;
    logic           div_by_zero;

    modport master (
        output start, a_mag, a_sign, b_mag, b_sign,
        input  busy, done, q_mag, q_sign, r_mag, r_sign, div_by_zero
    );

    modport slave (
        input  start, a_mag, a_sign, b_mag, b_sign,
        output busy, done, q_mag, q_sign, r_mag, r_sign, div_by_zero
    );
endinterface

// File: rtl/div_restore_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor when it fits and report the resulting quotient bit.
module div_restore_step #(
    parameter int N = 4
) (
    input  logic [N:0]   r_i,
    input  logic         a_bit_i,
    input  logic [N-1:0] b_i,
    output logic [N:0]   r_next_o,
    output logic         qbit_o
);
    logic [N:0] r_shift;
    // The partial remainder is always below the divisor, so its MSB is zero.
    logic       unused_r_msb;

    assign unused_r_msb = r_i[N];

    // NOTE: every output gets a value on every path, so no latch is inferred.
    always_comb begin
        r_shift = {r_i[N-1:0], a_bit_i};
        if (r_shift >= {1'b0, b_i}) begin
            r_next_o = r_shift - {1'b0, b_i};
            qbit_o   = 1'b1;
        end else begin
            r_next_o = r_shift;
            qbit_o   = 1'b0;
        end
    end
endmodule

// File: rtl/div8s_seq.sv
// Sequential sign-magnitude restoring divider: 2N-bit dividend by N-bit
// divisor, one quotient bit per clock, truncation toward zero.
module div8s_seq
    import div8s_pkg::*;
#(
    parameter int N = DIV_N
) (
    input logic        clk,
    input logic        rst_n,
    div8s_seq_if.slave bus
);
    localparam int             CW   = cnt_width(N);
    localparam logic [CW-1:0]  LAST = CW'(2 * N - 1);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] a_sh_q, a_sh_d;
    logic [N-1:0]   b_q, b_d;
    logic           a_sign_q, a_sign_d;
    logic           b_sign_q, b_sign_d;
    logic [N:0]     rem_q, rem_d;
    logic [2*N-1:0] quo_q, quo_d;
    logic [2*N-1:0] q_mag_q, q_mag_d;
    logic           q_sign_q, q_sign_d;
    logic [N-1:0]   r_mag_q, r_mag_d;
    logic           r_sign_q, r_sign_d;
    logic           dbz_q, dbz_d;

    logic [N:0]     step_r;
    logic           step_qbit;
    logic [2*N-1:0] quo_next;

    div_restore_step #(.N(N)) u_step (
        .r_i      (rem_q),
        .a_bit_i  (a_sh_q[2*N-1]),
        .b_i      (b_q),
        .r_next_o (step_r),
        .qbit_o   (step_qbit)
    );

    assign quo_next = {quo_q[2*N-2:0], step_qbit};

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous
    // and also aborts an operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.start) state_d = (bus.b_mag == '0) ? S_DONE : S_RUN;
            S_RUN:   if (cnt_q == LAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_q == S_RUN);
        bus.done = (state_q == S_DONE);
    end

    always_comb begin
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_d      = b_q;
        a_sign_d = a_sign_q;
        b_sign_d = b_sign_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        q_mag_d  = q_mag_q;
        q_sign_d = q_sign_q;
        r_mag_d  = r_mag_q;
        r_sign_d = r_sign_q;
        dbz_d    = dbz_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_sh_d   = bus.a_mag;
                    b_d      = bus.b_mag;
                    a_sign_d = bus.a_sign;
                    b_sign_d = bus.b_sign;
                    rem_d    = '0;
                    quo_d    = '0;
                    cnt_d    = '0;
                    dbz_d    = 1'b0;
                    if (bus.b_mag == '0) begin
                        q_mag_d  = '1;
                        q_sign_d = 1'b0;
                        r_mag_d  = '0;
                        r_sign_d = 1'b0;
                        dbz_d    = 1'b1;
                    end
                end
            end
            S_RUN: begin
                a_sh_d = {a_sh_q[2*N-2:0], 1'b0};
                rem_d  = step_r;
                quo_d  = quo_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // Zero magnitudes never carry a negative sign.
                    q_mag_d  = quo_next;
                    q_sign_d = (a_sign_q ^ b_sign_q) & (|quo_next);
                    r_mag_d  = step_r[N-1:0];
                    r_sign_d = a_sign_q & (|step_r[N-1:0]);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_q      <= '0;
            a_sign_q <= 1'b0;
            b_sign_q <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            q_mag_q  <= '0;
            q_sign_q <= 1'b0;
            r_mag_q  <= '0;
            r_sign_q <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_q      <= b_d;
            a_sign_q <= a_sign_d;
            b_sign_q <= b_sign_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            q_mag_q  <= q_mag_d;
            q_sign_q <= q_sign_d;
            r_mag_q  <= r_mag_d;
            r_sign_q <= r_sign_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.q_mag       = q_mag_q;
    assign bus.q_sign      = q_sign_q;
    assign bus.r_mag       = r_mag_q;
    assign bus.r_sign      = r_sign_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div8s_seq.sv
// Self-checking bench for div8s_seq: directed cases plus random operands
// compared against a plain-arithmetic reference model.
module tb_div8s_seq;
    localparam int N = 4;

    typedef struct {
        int q;
        int qs;
        int r;
        int rs;
        int dbz;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    div8s_seq_if #(.N(N)) bus ();

    div8s_seq #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    // Truncating signed division with sign-magnitude results.
    function automatic exp_t model(input int a, input int as, input int b, input int bs);
        exp_t e;
        if (b == 0) begin
            e.q = 255; e.qs = 0; e.r = 0; e.rs = 0; e.dbz = 1;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.qs  = ((as != bs) && (e.q != 0)) ? 1 : 0;
            e.rs  = ((as != 0) && (e.r != 0)) ? 1 : 0;
            e.dbz = 0;
        end
        return e;
    endfunction

    task automatic check_results(input string tag, input exp_t e);
        check({tag, ".q_mag"}, 32'(bus.q_mag), e.q);
        check({tag, ".q_sign"}, 32'(bus.q_sign), e.qs);
        check({tag, ".r_mag"}, 32'(bus.r_mag), e.r);
        check({tag, ".r_sign"}, 32'(bus.r_sign), e.rs);
        check({tag, ".dbz"}, 32'(bus.div_by_zero), e.dbz);
    endtask

    task automatic run_op(input int a, input int as, input int b, input int bs, input string tag);
        exp_t e;
        int   n;
        int   busy_cnt;
        e = model(a, as, b, bs);
        bus.start  = 1'b1;
        bus.a_mag  = 8'(a);
        bus.a_sign = 1'(as);
        bus.b_mag  = 4'(b);
        bus.b_sign = 1'(bs);
        tick();
        bus.start  = 1'b0;
        bus.a_mag  = 8'($urandom);
        bus.a_sign = 1'($urandom);
        bus.b_mag  = 4'($urandom);
        bus.b_sign = 1'($urandom);
        n = 0;
        busy_cnt = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            if (bus.busy === 1'b1) busy_cnt++;
            bus.start = (n == 2 || n == 5) ? 1'b1 : 1'b0;
            tick();
            n++;
        end
        bus.start = 1'b0;
        check({tag, ".latency"}, 32'(n), (b == 0) ? 0 : 2 * N);
        check({tag, ".busy_cycles"}, 32'(busy_cnt), (b == 0) ? 0 : 2 * N);
        check({tag, ".busy_at_done"}, 32'(bus.busy), 0);
        check_results(tag, e);
        tick();
        check({tag, ".done_pulse"}, 32'(bus.done), 0);
        check({tag, ".hold_q"}, 32'(bus.q_mag), e.q);
        check({tag, ".hold_r"}, 32'(bus.r_mag), e.r);
    endtask

    initial begin
        exp_t zero_e;
        int   done_seen;
        zero_e = '{q: 0, qs: 0, r: 0, rs: 0, dbz: 0};

        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.a_mag  = '0;
        bus.a_sign = 1'b0;
        bus.b_mag  = '0;
        bus.b_sign = 1'b0;
        tick();
        tick();
        check("reset.busy", 32'(bus.busy), 0);
        check("reset.done", 32'(bus.done), 0);
        check_results("reset", zero_e);
        rst_n = 1'b1;
        tick();

        run_op(100, 0, 7, 0, "pos100_pos7");
        run_op(100, 1, 7, 0, "neg100_pos7");
        run_op(225, 0, 1, 1, "pos225_neg1");
        run_op(3, 1, 5, 0, "neg3_pos5");
        run_op(9, 0, 0, 0, "div_zero");
        run_op(100, 0, 7, 0, "after_dbz");
        run_op(255, 1, 15, 1, "max_max");
        run_op(0, 1, 3, 1, "zero_dividend");

        // Abort mid-operation: reset lands on the 4th RUN edge.
        run_op(9, 1, 0, 1, "dbz_before_abort");
        bus.start  = 1'b1;
        bus.a_mag  = 8'd100;
        bus.a_sign = 1'b0;
        bus.b_mag  = 4'd7;
        bus.b_sign = 1'b0;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("abort.busy", 32'(bus.busy), 0);
        check("abort.done", 32'(bus.done), 0);
        check_results("abort", zero_e);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done === 1'b1) done_seen++;
            tick();
        end
        check("abort.no_done", 32'(done_seen), 0);
        run_op(100, 0, 7, 0, "restart");

        for (int i = 0; i < 40; i++) begin
            int b;
            b = (i % 8 == 7) ? 0 : int'($urandom_range(1, 15));
            run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 1)),
                   b, int'($urandom_range(0, 1)), $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
